pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers. Turns the hazard unit's load-use stall and mispredict flush, plus the data-memory wait, into per-stage enable and flush strobes.
- Adds a boot hold after reset and a multi-cycle flush window for fetch latency.
- Sits between the hazard unit and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- BOOT_CYCLES, 2, cycles all stages are held disabled and flushed after reset release (valid range 1..15).
- FLUSH_CYCLES, 1, cycles IF/ID stays flushed after a mispredict, including the detection cycle (valid range 1..15).
- CNT_WIDTH, 32, width of the performance counters (only when PIPE_PERF_EN is defined).

Ports:
- clk_in, input, 1, clock; all state updates on the rising edge.
- rst_n_in, input, 1, asynchronous active-low reset.
- stall_in, input, 1, load-use hazard request from the hazard unit.
- flush_in, input, 1, branch mispredict request from the hazard unit.
- dmem_busy_in, input, 1, data memory not ready; the whole pipeline must freeze.
- pc_en_out, output, 1, PC register write enable.
- ifid_en_out, output, 1, IF/ID register write enable.
- ifid_flush_out, output, 1, IF/ID clear to NOP.
- idex_en_out, output, 1, ID/EX register write enable.
- idex_flush_out, output, 1, ID/EX clear to bubble.
- exmem_en_out, output, 1, EX/MEM write enable.
- memwb_en_out, output, 1, MEM/WB write enable.
- state_out, output, 2, current FSM state: 0 = BOOT, 1 = RUN, 2 = FLUSH.

Behaviour:
- Registered state: FSM state plus a 4-bit down-counter `cnt`. All outputs are combinational functions of state, `cnt` and the current inputs, so they take effect in the same cycle as the request.
- Reset (rst_n_in low, asynchronous):
  - state = BOOT, `cnt` = BOOT_CYCLES-1.
  - Outputs during reset: all `*_en_out` = 0, `ifid_flush_out` = `idex_flush_out` = 1, `state_out` = 0.
  - Reset asserted in any state, mid-operation, returns to BOOT immediately.
- Global freeze, highest priority, any state except BOOT:
  - When `dmem_busy_in` = 1, all enables = 0 and all flushes = 0.
  - State and `cnt` hold.
  - `stall_in` and `flush_in` are ignored that cycle and are re-evaluated on the first non-busy cycle.
- BOOT:
  - Outputs as in reset. `dmem_busy_in` is ignored.
  - `cnt` decrements each cycle. When `cnt` = 0, go to RUN next cycle.
  - Total hold is exactly BOOT_CYCLES cycles after reset release.
- RUN, not busy:
  - flush_in = 1 (wins over stall_in):
    - pc_en = 1 so the PC loads the redirect target.
    - ifid_flush = 1, idex_flush = 1; ifid_en, idex_en, exmem_en, memwb_en = 1.
    - If FLUSH_CYCLES > 1, go to FLUSH with `cnt` = FLUSH_CYCLES-2; otherwise stay in RUN.
  - else stall_in = 1:
    - pc_en = 0, ifid_en = 0.
    - idex_flush = 1 (bubble); exmem_en = memwb_en = 1; ifid_flush = 0.
    - Stay in RUN; one bubble per cycle that stall_in is asserted.
  - else: all enables = 1, flushes = 0.
- FLUSH, not busy:
  - pc_en = 1, ifid_flush = 1, all enables = 1.
  - idex_flush = 1 only if flush_in = 1.
  - stall_in is ignored, because the instruction in ID is being squashed.
  - flush_in = 1 reloads `cnt` = FLUSH_CYCLES-2 (re-redirect). Otherwise, if `cnt` = 0 go to RUN, else decrement `cnt`.
- Invariant: an `*_en_out` and its matching `*_flush_out` may both be 1; flush has priority inside the register.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined: adds outputs `stall_cnt_out` [CNT_WIDTH] and `flush_cnt_out` [CNT_WIDTH], plus input `cnt_clr_in`.
  - `stall_cnt_out` increments on each RUN-state non-busy cycle with stall_in = 1 and flush_in = 0.
  - `flush_cnt_out` increments on each non-busy cycle with flush_in = 1 in RUN or FLUSH.
  - Both counters saturate at all-ones and reset to 0.
  - `cnt_clr_in` = 1 zeroes both synchronously and has priority over increment.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then release, idle inputs, BOOT_CYCLES=2:
  - Enables are 0 and flushes 1 for exactly 2 cycles after release.
  - Cycle 3 has state_out = 1 and all enables = 1.
- stall_in pulsed for 1 cycle in RUN:
  - That cycle: pc_en = ifid_en = 0, idex_flush = 1, exmem_en = 1.
  - Next cycle: all enables = 1.
- flush_in and stall_in asserted together, FLUSH_CYCLES=3:
  - Detection cycle: ifid_flush = idex_flush = 1, pc_en = 1, state → FLUSH.
  - ifid_flush stays 1 for 2 more cycles, then state_out = 1.
- dmem_busy_in held 4 cycles in the middle of the FLUSH window: all enables = 0 and flushes = 0 for those 4 cycles. Then the remaining FLUSH cycles complete unchanged.
- rst_n_in dropped asynchronously mid-FLUSH: outputs go immediately to reset values and state_out = 0, with no clock edge required.
- With PIPE_PERF_EN: 5 stalls and 2 flushes give stall_cnt_out = 5 and flush_cnt_out = 2. Pulsing cnt_clr_in gives 0 for both the next cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline register sequencer: turns hazard stall/flush and dmem wait into per-stage enable/flush strobes.
// Optional performance counters (stall/flush event counts) are built when PIPE_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned FLUSH_CYCLES = 1
`ifdef PIPE_PERF_EN
  ,
  parameter int unsigned CNT_WIDTH    = 32
`endif
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       stall_in,
  input  logic       flush_in,
  input  logic       dmem_busy_in,
  output logic       pc_en_out,
  output logic       ifid_en_out,
  output logic       ifid_flush_out,
  output logic       idex_en_out,
  output logic       idex_flush_out,
  output logic       exmem_en_out,
  output logic       memwb_en_out,
  output logic [1:0] state_out
`ifdef PIPE_PERF_EN
  ,
  input  logic                 cnt_clr_in,
  output logic [CNT_WIDTH-1:0] stall_cnt_out,
  output logic [CNT_WIDTH-1:0] flush_cnt_out
`endif
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] BOOT_LOAD  = CW'(BOOT_CYCLES - 32'd1);
  // Only meaningful when the flush window spans more than the detection cycle.
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 32'd2);
  localparam logic          MULTI_FLUSH = (FLUSH_CYCLES > 32'd1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  // State and window counter register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_BOOT;
      cnt   <= BOOT_LOAD;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state and same-cycle strobes; dmem wait freezes everything outside BOOT.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    pc_en_out      = 1'b0;
    ifid_en_out    = 1'b0;
    ifid_flush_out = 1'b0;
    idex_en_out    = 1'b0;
    idex_flush_out = 1'b0;
    exmem_en_out   = 1'b0;
    memwb_en_out   = 1'b0;

    case (state)
      ST_BOOT: begin
        ifid_flush_out = 1'b1;
        idex_flush_out = 1'b1;
        if (cnt == '0) begin
          state_nx = ST_RUN;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end

      ST_RUN: begin
        if (!dmem_busy_in) begin
          exmem_en_out = 1'b1;
          memwb_en_out = 1'b1;
          idex_en_out  = 1'b1;
          if (flush_in) begin
            pc_en_out      = 1'b1;
            ifid_en_out    = 1'b1;
            ifid_flush_out = 1'b1;
            idex_flush_out = 1'b1;
            if (MULTI_FLUSH) begin
              state_nx = ST_FLUSH;
              cnt_nx   = FLUSH_LOAD;
            end
          end else if (stall_in) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX.
            idex_flush_out = 1'b1;
          end else begin
            pc_en_out   = 1'b1;
            ifid_en_out = 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        if (!dmem_busy_in) begin
          pc_en_out      = 1'b1;
          ifid_en_out    = 1'b1;
          ifid_flush_out = 1'b1;
          idex_en_out    = 1'b1;
          idex_flush_out = flush_in;
          exmem_en_out   = 1'b1;
          memwb_en_out   = 1'b1;
          if (flush_in) begin
            cnt_nx = FLUSH_LOAD;
          end else if (cnt == '0) begin
            state_nx = ST_RUN;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
      end

      default: begin
        state_nx = ST_BOOT;
        cnt_nx   = BOOT_LOAD;
      end
    endcase
  end

  assign state_out = state;

`ifdef PIPE_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = (state == ST_RUN) && !dmem_busy_in && stall_in && !flush_in;
  assign flush_evt = ((state == ST_RUN) || (state == ST_FLUSH)) && !dmem_busy_in && flush_in;

  // Saturating event counters; clear wins over increment.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_cnt_out <= '0;
      flush_cnt_out <= '0;
    end else if (cnt_clr_in) begin
      stall_cnt_out <= '0;
      flush_cnt_out <= '0;
    end else begin
      if (stall_evt && (stall_cnt_out != '1)) begin
        stall_cnt_out <= stall_cnt_out + CNT_WIDTH'(1);
      end
      if (flush_evt && (flush_cnt_out != '1)) begin
        flush_cnt_out <= flush_cnt_out + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule
